// File: rtl/kw_pkg.sv
// Shared definitions for the keyword tokenizer: token classes, match-FSM states,
// ASCII constants and case-fold helper.
package kw_pkg;

    localparam logic [1:0] TOK_NONE  = 2'd0;
    localparam logic [1:0] TOK_BEGIN = 2'd1;
    localparam logic [1:0] TOK_END   = 2'd2;
    localparam logic [1:0] TOK_WORD  = 2'd3;

    typedef enum logic [3:0] {
        ST_GAP   = 4'd0,
        ST_B     = 4'd1,
        ST_BE    = 4'd2,
        ST_BEG   = 4'd3,
        ST_BEGI  = 4'd4,
        ST_BEGIN = 4'd5,
        ST_E     = 4'd6,
        ST_EN    = 4'd7,
        ST_END   = 4'd8,
        ST_OTHER = 4'd9
    } state_t;

    localparam logic [7:0] ASCII_UP_A     = 8'h41;
    localparam logic [7:0] ASCII_UP_Z     = 8'h5A;
    localparam logic [7:0] ASCII_LO_A     = 8'h61;
    localparam logic [7:0] ASCII_LO_Z     = 8'h7A;
    localparam logic [7:0] ASCII_CASE_OFS = 8'h20;
    localparam logic [7:0] ASCII_LO_B     = 8'h62;
    localparam logic [7:0] ASCII_LO_D     = 8'h64;
    localparam logic [7:0] ASCII_LO_E     = 8'h65;
    localparam logic [7:0] ASCII_LO_G     = 8'h67;
    localparam logic [7:0] ASCII_LO_I     = 8'h69;
    localparam logic [7:0] ASCII_LO_N     = 8'h6E;

    // Upper-case letters move to lower case; every other byte is unchanged.
    function automatic logic [7:0] fold_lower(input logic [7:0] ch);
        logic [7:0] res;
        res = ch;
        if (ch >= ASCII_UP_A && ch <= ASCII_UP_Z) begin
            res = ch + ASCII_CASE_OFS;
        end
        return res;
    endfunction

    function automatic logic [1:0] kind_of(input state_t st);
        logic [1:0] k;
        case (st)
            ST_BEGIN: k = TOK_BEGIN;
            ST_END:   k = TOK_END;
            ST_GAP:   k = TOK_NONE;
            default:  k = TOK_WORD;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/kw_char_class.sv
// Combinational letter test and lower-case fold for one input byte.
module kw_char_class
    import kw_pkg::*;
(
    input  logic [7:0] ch,
    output logic       letter_c,
    output logic [7:0] lower_c
);

    // After folding, only letters land in 'a'..'z'.
    always_comb begin
        lower_c  = fold_lower(ch);
        letter_c = (lower_c >= ASCII_LO_A) && (lower_c <= ASCII_LO_Z);
    end

endmodule

// File: rtl/keyword_tokenizer.sv
// Splits an ASCII byte stream into words and emits one BEGIN/END/WORD token per word.
// Optional nesting-depth tracker enabled by defining KEYWORD_TOKENIZER_DEPTH_EN.
module keyword_tokenizer
    import kw_pkg::*;
#(
    parameter int unsigned LEN_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in,
    input  logic             flush,
    output logic             tok_valid,
    output logic [1:0]       tok_kind,
    output logic [LEN_W-1:0] tok_len,
    output logic             busy
`ifdef KEYWORD_TOKENIZER_DEPTH_EN
    ,
    output logic signed [7:0] depth,
    output logic              underflow,
    output logic              balanced
`endif
);

    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    state_t           st_a;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_nxt;
    logic [LEN_W-1:0] len_a;
    logic             close;
    logic             emit;
    logic [1:0]       emit_kind;
    logic [LEN_W-1:0] emit_len;
    logic             letter_c;
    logic [7:0]       lower_c;

    kw_char_class u_char_class (
        .ch       (in),
        .letter_c (letter_c),
        .lower_c  (lower_c)
    );

    function automatic state_t advance(input state_t st, input logic [7:0] ch);
        state_t n;
        n = ST_OTHER;
        case (st)
            ST_GAP: begin
                if (ch == ASCII_LO_B)      n = ST_B;
                else if (ch == ASCII_LO_E) n = ST_E;
            end
            ST_B:    if (ch == ASCII_LO_E) n = ST_BE;
            ST_BE:   if (ch == ASCII_LO_G) n = ST_BEG;
            ST_BEG:  if (ch == ASCII_LO_I) n = ST_BEGI;
            ST_BEGI: if (ch == ASCII_LO_N) n = ST_BEGIN;
            ST_E:    if (ch == ASCII_LO_N) n = ST_EN;
            ST_EN:   if (ch == ASCII_LO_D) n = ST_END;
            default: n = ST_OTHER;
        endcase
        return n;
    endfunction

    // The byte is applied first (st_a/len_a); a delimiter or flush then closes the word.
    always_comb begin
        st_a      = state;
        len_a     = len;
        close     = 1'b0;
        state_nxt = state;
        len_nxt   = len;
        emit      = 1'b0;
        emit_kind = TOK_NONE;
        emit_len  = '0;

        if (in_valid && letter_c) begin
            st_a  = advance(state, lower_c);
            len_a = (len == LEN_MAX) ? len : len + LEN_W'(1);
        end

        close = (in_valid && !letter_c) || flush;

        if (close) begin
            state_nxt = ST_GAP;
            len_nxt   = '0;
            if (st_a != ST_GAP) begin
                emit      = 1'b1;
                emit_kind = kind_of(st_a);
                emit_len  = len_a;
            end
        end else begin
            state_nxt = st_a;
            len_nxt   = len_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_GAP;
            len       <= '0;
            tok_valid <= 1'b0;
            tok_kind  <= TOK_NONE;
            tok_len   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            len       <= len_nxt;
            tok_valid <= emit;
            tok_kind  <= emit_kind;
            tok_len   <= emit_len;
            busy      <= (state_nxt != ST_GAP);
        end
    end

`ifdef KEYWORD_TOKENIZER_DEPTH_EN
    logic signed [7:0] depth_nxt;
    logic              underflow_nxt;

    // Depth never goes negative: an unmatched END only raises the sticky flag.
    always_comb begin
        depth_nxt     = depth;
        underflow_nxt = underflow;
        if (emit && emit_kind == TOK_BEGIN) begin
            if (depth != 8'sd127) depth_nxt = depth + 8'sd1;
        end else if (emit && emit_kind == TOK_END) begin
            if (depth == 8'sd0) underflow_nxt = 1'b1;
            else                depth_nxt     = depth - 8'sd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth     <= 8'sd0;
            underflow <= 1'b0;
            balanced  <= 1'b1;
        end else begin
            depth     <= depth_nxt;
            underflow <= underflow_nxt;
            balanced  <= (depth_nxt == 8'sd0) && !underflow_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_keyword_tokenizer.sv
// Directed self-checking bench for keyword_tokenizer; depth checks compile in
// when KEYWORD_TOKENIZER_DEPTH_EN is defined.
module tb_keyword_tokenizer;

    localparam int unsigned LEN_W = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [7:0]       in_byte;
    logic             flush;
    logic             tok_valid;
    logic [1:0]       tok_kind;
    logic [LEN_W-1:0] tok_len;
    logic             busy;
`ifdef KEYWORD_TOKENIZER_DEPTH_EN
    logic signed [7:0] depth;
    logic              underflow;
    logic              balanced;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int q_kind[$];
    int q_len[$];
    int q_idx[$];

    keyword_tokenizer #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (in_byte),
        .flush     (flush),
        .tok_valid (tok_valid),
        .tok_kind  (tok_kind),
        .tok_len   (tok_len),
        .busy      (busy)
`ifdef KEYWORD_TOKENIZER_DEPTH_EN
        ,
        .depth     (depth),
        .underflow (underflow),
        .balanced  (balanced)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Apply one cycle of inputs (called at negedge), sample just after the edge.
    task automatic step(input logic v, input logic [7:0] b, input logic fl);
        in_valid = v;
        in_byte  = b;
        flush    = fl;
        @(posedge clk);
        #1;
        if (tok_valid) begin
            q_kind.push_back(int'(tok_kind));
            q_len.push_back(int'(tok_len));
            q_idx.push_back(cyc);
        end
        cyc++;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
    endtask

    task automatic clear_q();
        q_kind.delete();
        q_len.delete();
        q_idx.delete();
    endtask

    int base;

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        flush    = 1'b0;
        @(negedge clk);
        do_reset();
        check("rst_tok_valid", int'(tok_valid), 0);
        check("rst_tok_kind", int'(tok_kind), 0);
        check("rst_tok_len", int'(tok_len), 0);
        check("rst_busy", int'(busy), 0);
`ifdef KEYWORD_TOKENIZER_DEPTH_EN
        check("rst_balanced", int'(balanced), 1);
`endif

        // "begin end " with exact strobe timing
        clear_q();
        base = cyc;
        step(1'b1, 8'h62, 1'b0);
        check("busy_open", int'(busy), 1);
        send("egin end ");
        check("t1_count", q_kind.size(), 2);
        if (q_kind.size() == 2) begin
            check("t1_kind0", q_kind[0], 1);
            check("t1_len0", q_len[0], 5);
            check("t1_idx0", q_idx[0] - base, 5);
            check("t1_kind1", q_kind[1], 2);
            check("t1_len1", q_len[1], 3);
            check("t1_idx1", q_idx[1] - base, 9);
        end
        check("t1_busy_gap", int'(busy), 0);

        // mixed case with LF delimiter
        clear_q();
        send("BeGiN\n");
        check("t2_count", q_kind.size(), 1);
        if (q_kind.size() == 1) begin
            check("t2_kind", q_kind[0], 1);
            check("t2_len", q_len[0], 5);
        end

        // keyword followed by extra letters is a plain WORD
        clear_q();
        send("beginx endd ");
        check("t3_count", q_kind.size(), 2);
        if (q_kind.size() == 2) begin
            check("t3_kind0", q_kind[0], 3);
            check("t3_len0", q_len[0], 6);
            check("t3_kind1", q_kind[1], 3);
            check("t3_len1", q_len[1], 4);
        end

        // flush with a letter; idle cycle in the middle holds the word
        clear_q();
        step(1'b1, 8'h61, 1'b0);
        step(1'b0, 8'h20, 1'b0);
        check("t4_idle_hold", int'(tok_valid), 0);
        step(1'b1, 8'h62, 1'b1);
        check("t4_flush_strobe", int'(tok_valid), 1);
        step(1'b0, 8'h00, 1'b1);
        check("t4_gap_flush", int'(tok_valid), 0);
        check("t4_count", q_kind.size(), 1);
        if (q_kind.size() == 1) begin
            check("t4_kind", q_kind[0], 3);
            check("t4_len", q_len[0], 2);
        end

        // delimiter together with flush yields a single token
        clear_q();
        send("end");
        step(1'b1, 8'h2C, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check("t4b_count", q_kind.size(), 1);
        if (q_kind.size() == 1) check("t4b_kind", q_kind[0], 2);

        // length saturation
        clear_q();
        for (int i = 0; i < 70; i++) step(1'b1, 8'h61, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        check("t5_quiet_kind", int'(tok_kind), 0);
        check("t5_quiet_len", int'(tok_len), 0);
        check("t5_count", q_kind.size(), 1);
        if (q_kind.size() == 1) begin
            check("t5_kind", q_kind[0], 3);
            check("t5_len", q_len[0], 63);
        end

        // reset mid-word discards it
        clear_q();
        send("begi");
        do_reset();
        check("t6_busy_after_rst", int'(busy), 0);
        send("n ");
        check("t6_count", q_kind.size(), 1);
        if (q_kind.size() == 1) begin
            check("t6_kind", q_kind[0], 3);
            check("t6_len", q_len[0], 1);
        end

`ifdef KEYWORD_TOKENIZER_DEPTH_EN
        do_reset();
        send("end ");
        check("d_underflow", int'(underflow), 1);
        check("d_depth0", int'(depth), 0);
        send("begin ");
        check("d_depth1", int'(depth), 1);
        check("d_underflow_sticky", int'(underflow), 1);
        check("d_balanced", int'(balanced), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/keyword_tokenizer.md
Name: keyword_tokenizer

Overview:
- Upstream stage of the begin/end block checker.
- Consumes a raw ASCII byte stream, folds case, splits it into words, and classifies each completed word as BEGIN, END or WORD.
- Emits one single-cycle token per word, so the checker operates on clean keyword events instead of re-parsing characters and space state itself.

Parameters:
- LEN_W, 6, width of the word-length counter and of tok_len; the length saturates at 2^LEN_W-1.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, in carries a byte this cycle.
- in, input, 8, ASCII byte.
- flush, input, 1, end of stream; terminates any open word.
- tok_valid, output, 1, single-cycle token strobe.
- tok_kind, output, 2, token class: 0 NONE, 1 BEGIN, 2 END, 3 WORD.
- tok_len, output, LEN_W, letter count of the emitted word (saturated).
- busy, output, 1, a word is currently open (state != GAP).

Behaviour:
- Reset is synchronous and active-high on clk.
  - While reset is high, the next edge sets: state=GAP, len=0, tok_valid=0, tok_kind=0, tok_len=0.
  - Reset asserted mid-word discards that word; no token is emitted for it.
- Letter: a byte in 'A'..'Z' or 'a'..'z'. Upper case is folded to lower case with +32.
- Delimiter: any other byte, including space, digits, punctuation, CR and LF.
- Match FSM states: GAP, B, BE, BEG, BEGI, BEGIN, E, EN, END, OTHER.
- Letter transitions:
  - From GAP: 'b' goes to B, 'e' goes to E, anything else goes to OTHER.
  - Each prefix state advances only on its next expected letter, otherwise it goes to OTHER.
  - BEGIN, END and OTHER go to OTHER on any letter. For example "beginx" and "ends" are WORD.
- Delimiter handling:
  - From BEGIN: emit BEGIN.
  - From END: emit END.
  - From any other non-GAP state: emit WORD.
  - From GAP: no emission.
  - In all cases the next state is GAP.
- Consecutive delimiters produce nothing.
- Length counter:
  - Cleared on entry to GAP.
  - Incremented on every letter, saturating at 2^LEN_W-1.
  - tok_len carries the count including the final letter.
- Token outputs are registered: tok_valid/kind/len are asserted on the edge that accepts the terminating delimiter. They are visible the following cycle and last exactly one cycle.
- When no token is emitted, tok_kind=0 and tok_len=0.
- in_valid=0: the FSM holds and no token is emitted, unless flush is high.
- flush:
  - Terminates the open word exactly like a delimiter.
  - If in_valid and flush are high together, the byte is processed first. A letter extends the word and flush then closes it, producing one token that includes the letter. A delimiter closes the word and flush adds no second token.
  - flush in GAP does nothing.
- Maximum throughput is one byte per cycle. There is no backpressure, and at most one token is produced per cycle.

Optional Feature:
- Macro: KEYWORD_TOKENIZER_DEPTH_EN.
- With the macro defined, extra outputs are added:
  - depth (8 bits, signed): +1 on each BEGIN token, -1 on each END token; reset value 0.
  - underflow (1 bit): sticky; set when an END arrives at depth 0, after which depth stays at 0. Cleared only by reset.
  - balanced (1 bit): depth==0 && !underflow.
- Without the macro these ports and their logic do not exist, and the token behaviour is identical.

Decomposition:
- Shared package kw_pkg holds:
  - tok_kind constants: TOK_NONE=0, TOK_BEGIN=1, TOK_END=2, TOK_WORD=3.
  - FSM state encodings (4 bits).
  - ASCII constants.
  - A lowercase-fold function.
- One natural sub-module: kw_char_class, a combinational letter test and case fold feeding the FSM.
- The FSM, the counter and the optional depth tracker stay in the top module.

Test Plan:
- Stream "begin end " with in_valid continuous:
  - BEGIN with len=5 strobed the cycle after the first space.
  - END with len=3 strobed after the second space.
  - No other tokens.
- Stream "BeGiN\n" → a single BEGIN, len=5. Stream "beginx endd " → WORD len=6, then WORD len=4.
- Stream "ab" with flush asserted together with 'b' → a single WORD, len=2. A second flush in GAP produces no token.
- Word of 70 'a' letters followed by a space with LEN_W=6 → WORD with tok_len=63. A following space produces no token.
- Send "begi", assert reset for one cycle, then send "n " → WORD len=1 only. busy=0 the cycle after reset.
- With KEYWORD_TOKENIZER_DEPTH_EN defined, stream "end begin " → underflow=1, depth=1 after the BEGIN, balanced=0.
